systolic_fifo_p: RTL and testbench

Parametrised successor to the systolic-array data FIFO: single clock, DEPTH x DW storage, registered read port with a one-cycle read-valid.
Adds exact occupancy, separate full, empty and almost-full flags, a stall input that freezes both ends, synchronous flush, and sticky overflow/underflow error flags.
Sits between systolic PEs and between the array edge and the loaders, one instance per lane.

---
 rtl/systolic_fifo_p.sv | 109 ++++++++++
 tb/tb_systolic_fifo_p.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_fifo_p.sv
// Lane FIFO between systolic PEs: DEPTH x DW storage, registered read port with a
// one-cycle read-valid, exact occupancy, almost-full/full/empty, stall, flush, sticky errors.
module systolic_fifo_p #(
    parameter int DW       = 16,
    parameter int DEPTH    = 4,
    parameter int AF_SLACK = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [DW-1:0]            din,
    input  logic                     re,
    input  logic                     is,
    input  logic                     flush,
    output logic [DW-1:0]            dout,
    output logic                     rv,
    output logic                     ff,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     udf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_AF   = (AW+1)'(DEPTH - AF_SLACK);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          rv_q, rv_d, ovf_q, ovf_d, udf_q, udf_d;
    logic          full_w, empty_w, pop_ok, push_ok, ovf_ev, udf_ev;

    // Flags come from the registered count only, so we/re never reach an output combinationally.
    assign full_w  = (count_q == CNT_FULL);
    assign empty_w = (count_q == '0);

    assign pop_ok  = re & ~is & ~flush & ~empty_w;
    assign push_ok = we & ~is & ~flush & (~full_w | pop_ok);
    assign ovf_ev  = we & ~is & ~flush & full_w & ~pop_ok;
    assign udf_ev  = re & ~is & ~flush & empty_w;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = dout_q;
        rv_d    = 1'b0;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (push_ok) wptr_d = wptr_q + PTR_ONE;
            if (pop_ok) begin
                rptr_d = rptr_q + PTR_ONE;
                dout_d = mem_q[rptr_q];
                rv_d   = 1'b1;
            end
            if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
            else if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
            if (ovf_ev) ovf_d = 1'b1;
            if (udf_ev) udf_d = 1'b1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            rv_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            rv_q    <= rv_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign dout  = dout_q;
    assign rv    = rv_q;
    assign count = count_q;
    assign full  = full_w;
    assign empty = empty_w;
    assign ff    = (count_q >= CNT_AF);
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: tb/tb_systolic_fifo_p.sv
// Scoreboard bench for systolic_fifo_p: a DEPTH=4/DW=16 lane driven through
// fill, wrap, error, stall, flush and async-reset sequences, plus a DEPTH=8/DW=32 lane.
module tb_systolic_fifo_p;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we, re, is, flush;
    logic [15:0] din;
    logic [15:0] dout;
    logic        rv, ff, full, empty, ovf, udf;
    logic [2:0]  count;

    logic        we8, re8, is8, flush8;
    logic [31:0] din8, dout8;
    logic        rv8, ff8, full8, empty8, ovf8, udf8;
    logic [3:0]  count8;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state for the DEPTH=4 lane
    logic [15:0] sb[$];
    logic [31:0] sb8[$];
    int          m_cnt;
    logic [15:0] m_dout;
    logic        m_rv, m_ovf, m_udf;

    always #5 clk = ~clk;

    systolic_fifo_p #(.DW(16), .DEPTH(4), .AF_SLACK(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .we(we), .din(din), .re(re), .is(is), .flush(flush),
        .dout(dout), .rv(rv), .ff(ff), .full(full), .empty(empty), .count(count),
        .ovf(ovf), .udf(udf)
    );

    systolic_fifo_p #(.DW(32), .DEPTH(8), .AF_SLACK(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .we(we8), .din(din8), .re(re8), .is(is8), .flush(flush8),
        .dout(dout8), .rv(rv8), .ff(ff8), .full(full8), .empty(empty8), .count(count8),
        .ovf(ovf8), .udf(udf8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        sb.delete();
        m_cnt  = 0;
        m_dout = '0;
        m_rv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rv"},    {31'd0, rv},    {31'd0, m_rv});
        check({tag, ".dout"},  {16'd0, dout},  {16'd0, m_dout});
        check({tag, ".count"}, {29'd0, count}, m_cnt);
        check({tag, ".full"},  {31'd0, full},  {31'd0, m_cnt == 4});
        check({tag, ".empty"}, {31'd0, empty}, {31'd0, m_cnt == 0});
        check({tag, ".ff"},    {31'd0, ff},    {31'd0, m_cnt >= 2});
        check({tag, ".ovf"},   {31'd0, ovf},   {31'd0, m_ovf});
        check({tag, ".udf"},   {31'd0, udf},   {31'd0, m_udf});
    endtask

    // One clock of the DEPTH=4 lane: drive, step the model from pre-edge state, compare.
    task automatic cyc(input string tag, input logic w, input logic [15:0] d,
                       input logic r, input logic s, input logic f);
        logic m_full, m_empty, pop, push;
        we = w; din = d; re = r; is = s; flush = f;
        m_full  = (m_cnt == 4);
        m_empty = (m_cnt == 0);
        @(posedge clk);
        #1;
        if (f) begin
            sb.delete();
            m_cnt = 0;
            m_rv  = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            pop  = r & ~s & ~m_empty;
            push = w & ~s & (~m_full | pop);
            m_rv = pop;
            if (pop) m_dout = sb.pop_front();
            if (push) sb.push_back(d);
            if (push && !pop) m_cnt++;
            if (pop && !push) m_cnt--;
            if (w & ~s & m_full & ~pop) m_ovf = 1'b1;
            if (r & ~s & m_empty) m_udf = 1'b1;
        end
        check_all(tag);
        if (rv) check({tag, ".no_aaaa"}, {31'd0, dout == 16'hAAAA}, 32'd0);
        we = 1'b0; re = 1'b0; is = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        we = 0; re = 0; is = 0; flush = 0; din = '0;
        we8 = 0; re8 = 0; is8 = 0; flush8 = 0; din8 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Fill then drain
        for (int i = 1; i <= 4; i++) cyc("fill", 1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc("drain_idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Steady-state push/pop at occupancy 2, pointers wrap repeatedly
        cyc("wrap_pre", 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
        cyc("wrap_pre", 1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc("wrap", 1'b1, 16'h0020 + 16'(i), 1'b1, 1'b0, 1'b0);
        cyc("wrap_post", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc("wrap_post", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Overflow, simultaneous push/pop while full, underflow
        for (int i = 0; i < 4; i++) cyc("ovf_fill", 1'b1, 16'h0030 + 16'(i), 1'b0, 1'b0, 1'b0);
        cyc("ovf_push", 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        cyc("full_both", 1'b1, 16'h0040, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("ovf_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc("udf_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc("udf_idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cyc("empty_both", 1'b1, 16'h0050, 1'b1, 1'b0, 1'b0);
        cyc("err_flush", 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Stall holds everything
        cyc("stall_pre", 1'b1, 16'h0061, 1'b0, 1'b0, 1'b0);
        cyc("stall_pre", 1'b1, 16'h0062, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("stall", 1'b1, 16'h0055, 1'b1, 1'b1, 1'b0);
        cyc("stall_rel", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc("stall_rel", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush with a concurrent push while count=3 and ovf=1
        for (int i = 0; i < 4; i++) cyc("fl_fill", 1'b1, 16'h0070 + 16'(i), 1'b0, 1'b0, 1'b0);
        cyc("fl_ovf", 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        cyc("fl_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc("flush", 1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1);
        cyc("fl_push", 1'b1, 16'h0077, 1'b0, 1'b0, 1'b0);
        cyc("fl_pop2", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc("fl_idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Async reset between edges while rv is high
        cyc("ar_fill", 1'b1, 16'h0081, 1'b0, 1'b0, 1'b0);
        cyc("ar_fill", 1'b1, 16'h0082, 1'b0, 1'b0, 1'b0);
        cyc("ar_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("ar_after", 1'b1, 16'h0091, 1'b0, 1'b0, 1'b0);
        cyc("ar_after", 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // DEPTH=8, DW=32, AF_SLACK=3 lane: ff from count 5
        for (int i = 0; i < 8; i++) begin
            we8 = 1'b1;
            din8 = 32'hC0DE_0000 + 32'(i);
            sb8.push_back(din8);
            @(posedge clk);
            #1;
            check("d8.count", {28'd0, count8}, i + 1);
            check("d8.ff",    {31'd0, ff8},    {31'd0, (i + 1) >= 5});
            check("d8.full",  {31'd0, full8},  {31'd0, i == 7});
        end
        we8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] exp8;
            re8 = 1'b1;
            @(posedge clk);
            #1;
            check("d8.rv", {31'd0, rv8}, 32'd1);
            exp8 = (sb8.size() > 0) ? sb8.pop_front() : 32'hDEAD_DEAD;
            check("d8.dout", dout8, exp8);
        end
        re8 = 1'b0;
        @(posedge clk);
        #1;
        check("d8.rv_end", {31'd0, rv8},    32'd0);
        check("d8.empty",  {31'd0, empty8}, 32'd1);
        check("d8.errs",   {30'd0, ovf8, udf8}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
